// File: rtl/uart_rx_top.sv
// uart_rx_top: oversampling UART receiver (start, DATA_WIDTH data bits LSB
// first, optional parity, one stop bit; idle line high).
// Each bit is sampled three times around its centre and decided by a 2-of-3
// majority vote. Good frames load P_DATA and pulse Data_Valid; bad frames
// pulse Par_Err and/or Stp_Err and leave P_DATA unchanged.
//
// Parameters:
//   DATA_WIDTH  data bits per frame
//   OVERSAMPLE  clocks per bit (8, 16 or 32)
// Ports:
//   CLK         system clock, rising edge
//   RST         synchronous active-low reset
//   RX_In       serial line, idle high
//   Par_En      1 = frame carries a parity bit (latched at the start edge)
//   Par_Type    0 = even, 1 = odd parity (latched at the start edge)
//   P_DATA      last correctly received word
//   Data_Valid  one-cycle pulse, P_DATA updated
//   Par_Err     one-cycle pulse, parity mismatch
//   Stp_Err     one-cycle pulse, stop bit sampled low
//   Busy        high while a frame is being received
// Build option:
//   UART_RX_SYNC_EN  adds a two-flop input synchronizer (+2 cycles latency)

module uart_rx_top #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned OVERSAMPLE = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_In,
    input  logic                  Par_En,
    input  logic                  Par_Type,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  Data_Valid,
    output logic                  Par_Err,
    output logic                  Stp_Err,
    output logic                  Busy
);

    localparam int unsigned EDGE_W = $clog2(OVERSAMPLE);
    localparam int unsigned BIT_W  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(OVERSAMPLE - 1);
    localparam logic [EDGE_W-1:0] SAMP_0    = EDGE_W'(OVERSAMPLE / 2 - 1);
    localparam logic [EDGE_W-1:0] SAMP_1    = EDGE_W'(OVERSAMPLE / 2);
    localparam logic [EDGE_W-1:0] SAMP_2    = EDGE_W'(OVERSAMPLE / 2 + 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    logic rx;

`ifdef UART_RX_SYNC_EN
    // Two-flop synchronizer, reset to the idle level
    logic [1:0] sync_q;

    always_ff @(posedge CLK) begin
        if (!RST) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], RX_In};
        end
    end

    assign rx = sync_q[1];
`else
    assign rx = RX_In;
`endif

    state_t                state, state_nxt;
    logic [EDGE_W-1:0]     edge_cnt, edge_nxt;
    logic [BIT_W-1:0]      bit_cnt, bit_nxt;
    logic [DATA_WIDTH-1:0] shreg, shreg_nxt;
    logic [2:0]            samp, samp_nxt;
    logic                  par_flag, par_flag_nxt;
    logic                  par_en_q, par_en_nxt;
    logic                  par_type_q, par_type_nxt;
    logic [DATA_WIDTH-1:0] p_data_nxt;
    logic                  valid_nxt, par_err_nxt, stp_err_nxt, busy_nxt;
    logic                  maj;
    logic                  begin_frame;

    // 2-of-3 vote over the centre samples of the current bit
    assign maj = (samp[0] & samp[1]) | (samp[0] & samp[2]) | (samp[1] & samp[2]);

    // State and datapath registers
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state      <= IDLE;
            edge_cnt   <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            samp       <= '0;
            par_flag   <= 1'b0;
            par_en_q   <= 1'b0;
            par_type_q <= 1'b0;
            P_DATA     <= '0;
            Data_Valid <= 1'b0;
            Par_Err    <= 1'b0;
            Stp_Err    <= 1'b0;
            Busy       <= 1'b0;
        end else begin
            state      <= state_nxt;
            edge_cnt   <= edge_nxt;
            bit_cnt    <= bit_nxt;
            shreg      <= shreg_nxt;
            samp       <= samp_nxt;
            par_flag   <= par_flag_nxt;
            par_en_q   <= par_en_nxt;
            par_type_q <= par_type_nxt;
            P_DATA     <= p_data_nxt;
            Data_Valid <= valid_nxt;
            Par_Err    <= par_err_nxt;
            Stp_Err    <= stp_err_nxt;
            Busy       <= busy_nxt;
        end
    end

    // Next-state, counters and output pulses
    always_comb begin
        state_nxt    = state;
        edge_nxt     = (edge_cnt == EDGE_LAST) ? '0 : edge_cnt + EDGE_W'(1);
        bit_nxt      = bit_cnt;
        shreg_nxt    = shreg;
        samp_nxt     = samp;
        par_flag_nxt = par_flag;
        par_en_nxt   = par_en_q;
        par_type_nxt = par_type_q;
        p_data_nxt   = P_DATA;
        valid_nxt    = 1'b0;
        par_err_nxt  = 1'b0;
        stp_err_nxt  = 1'b0;
        busy_nxt     = (state != IDLE);
        begin_frame  = 1'b0;

        if (state != IDLE) begin
            if (edge_cnt == SAMP_0) samp_nxt[0] = rx;
            if (edge_cnt == SAMP_1) samp_nxt[1] = rx;
            if (edge_cnt == SAMP_2) samp_nxt[2] = rx;
        end

        case (state)
            IDLE: begin
                edge_nxt    = '0;
                busy_nxt    = 1'b0;
                begin_frame = !rx;
            end
            START: begin
                if (edge_cnt == EDGE_LAST) begin
                    if (maj) begin
                        // Start bit did not hold: treat as a glitch
                        state_nxt = IDLE;
                        busy_nxt  = 1'b0;
                    end else begin
                        state_nxt = DATA;
                        bit_nxt   = '0;
                    end
                end
            end
            DATA: begin
                if (edge_cnt == EDGE_LAST) begin
                    shreg_nxt[bit_cnt] = maj;
                    if (bit_cnt == BIT_LAST) begin
                        state_nxt = par_en_q ? PARITY : STOP;
                    end else begin
                        bit_nxt = bit_cnt + BIT_W'(1);
                    end
                end
            end
            PARITY: begin
                if (edge_cnt == EDGE_LAST) begin
                    par_flag_nxt = (^shreg) ^ par_type_q ^ maj;
                    state_nxt    = STOP;
                end
            end
            STOP: begin
                if (edge_cnt == EDGE_LAST) begin
                    busy_nxt    = 1'b0;
                    state_nxt   = IDLE;
                    stp_err_nxt = !maj;
                    par_err_nxt = par_flag;
                    if (maj && !par_flag) begin
                        p_data_nxt = shreg;
                        valid_nxt  = 1'b1;
                    end
                    // A start bit right behind the stop bit is taken now
                    begin_frame = !rx;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        if (begin_frame) begin
            state_nxt    = START;
            edge_nxt     = '0;
            bit_nxt      = '0;
            par_flag_nxt = 1'b0;
            par_en_nxt   = Par_En;
            par_type_nxt = Par_Type;
        end
    end

endmodule

// File: tb/tb_uart_rx_top.sv
// tb_uart_rx_top: self-checking bench for uart_rx_top (OVERSAMPLE=8, 8 bits).
// Directed table of frames, hand-written corner sequences (busy window,
// back-to-back, start glitch, break, mid-frame reset) and random frames
// scored against an arithmetic frame model.

module tb_uart_rx_top;

    localparam int unsigned OS = 8;
    localparam int unsigned DW = 8;
`ifdef UART_RX_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic          CLK      = 1'b0;
    logic          RST      = 1'b0;
    logic          RX_In    = 1'b1;
    logic          Par_En   = 1'b0;
    logic          Par_Type = 1'b0;
    logic [DW-1:0] P_DATA;
    logic          Data_Valid;
    logic          Par_Err;
    logic          Stp_Err;
    logic          Busy;

    uart_rx_top #(.DATA_WIDTH(DW), .OVERSAMPLE(OS)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .RX_In      (RX_In),
        .Par_En     (Par_En),
        .Par_Type   (Par_Type),
        .P_DATA     (P_DATA),
        .Data_Valid (Data_Valid),
        .Par_Err    (Par_Err),
        .Stp_Err    (Stp_Err),
        .Busy       (Busy)
    );

    always #5 CLK = ~CLK;

    // Index of the most recent rising edge; read only at falling edges
    int edge_no = 0;
    always @(posedge CLK) edge_no <= edge_no + 1;

    int checks = 0;
    int passes = 0;

    typedef struct {
        int          cyc;
        bit          dv;
        bit          pe;
        bit          se;
        logic [7:0]  pdata;
    } exp_t;

    typedef struct {
        logic [7:0] data;
        bit         pen;
        bit         ptype;
        bit         bad_par;
        bit         bad_stop;
        int         off;
        bit         dv;
        bit         pe;
        bit         se;
        logic [7:0] pdata;
    } vec_t;

    exp_t       exp_q[$];
    exp_t       mon_e;
    logic [7:0] last_good = 8'h00;
    bit         mon_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at edge %0d", name, act, req, edge_no);
    endtask

    task automatic wait_edge(input int target);
        while (edge_no < target) @(negedge CLK);
    endtask

    // Frame outcome from the frame rules: N = 10 + parity bits, result lands
    // N bit-times after the start edge; errors keep the old word.
    function automatic exp_t model_frame(input logic [7:0] data, input bit pen,
                                         input bit bad_par, input bit bad_stop,
                                         input int t0, input logic [7:0] prev);
        exp_t e;
        e.cyc   = t0 + (10 + int'(pen)) * int'(OS) + LAT;
        e.pe    = pen && bad_par;
        e.se    = bad_stop;
        e.dv    = !(e.pe || e.se);
        e.pdata = e.dv ? data : prev;
        return e;
    endfunction

    // Drive one frame starting at the next rising edge; call right after a falling edge
    task automatic send_frame(input logic [7:0] data, input bit pen, input bit ptype,
                              input bit bad_par, input bit bad_stop,
                              input bit use_model, input exp_t tv);
        int   t0;
        int   n;
        bit   pbit;
        exp_t e;
        t0   = edge_no + 1;
        n    = 10 + int'(pen);
        pbit = (^data) ^ ptype ^ bad_par;
        if (use_model) begin
            e = model_frame(data, pen, bad_par, bad_stop, t0, last_good);
        end else begin
            e     = tv;
            e.cyc = t0 + tv.cyc + LAT;
        end
        last_good = e.pdata;
        exp_q.push_back(e);
        Par_En   = pen;
        Par_Type = ptype;
        for (int i = 0; i < n; i++) begin
            if (i == 0)                      RX_In = 1'b0;
            else if (i <= int'(DW))          RX_In = data[i-1];
            else if (pen && i == int'(DW)+1) RX_In = pbit;
            else                             RX_In = !bad_stop;
            // Configuration must be ignored once the frame has started
            if (i == 1) begin
                Par_En   = 1'($urandom);
                Par_Type = 1'($urandom);
            end
            repeat (OS) @(negedge CLK);
        end
        RX_In = 1'b1;
    endtask

    // Every expected result is scored at its cycle; any other pulse is an error
    always @(negedge CLK) begin
        if (mon_en) begin
            if (exp_q.size() > 0 && exp_q[0].cyc == edge_no) begin
                mon_e = exp_q.pop_front();
                chk("data_valid", 32'(Data_Valid), 32'(mon_e.dv));
                chk("par_err",    32'(Par_Err),    32'(mon_e.pe));
                chk("stp_err",    32'(Stp_Err),    32'(mon_e.se));
                chk("p_data",     32'(P_DATA),     32'(mon_e.pdata));
            end else if (Data_Valid || Par_Err || Stp_Err) begin
                chk("spurious_pulse", {29'd0, Data_Valid, Par_Err, Stp_Err}, 32'd0);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, edge %0d", edge_no);
        $fatal(1);
    end

    vec_t tbl[7];
    exp_t tv;
    exp_t none;
    int   tb0;

    initial begin
        //               data  pen pt  bp  bs  off dv pe se pdata
        tbl[0] = '{8'h3C, 1, 0, 0, 0, 88, 1, 0, 0, 8'h3C};
        tbl[1] = '{8'h3C, 1, 0, 1, 0, 88, 0, 1, 0, 8'h3C};
        tbl[2] = '{8'h5A, 0, 0, 0, 1, 80, 0, 0, 1, 8'h3C};
        tbl[3] = '{8'hC3, 1, 1, 0, 0, 88, 1, 0, 0, 8'hC3};
        tbl[4] = '{8'h81, 1, 1, 1, 1, 88, 0, 1, 1, 8'hC3};
        tbl[5] = '{8'hFF, 0, 1, 0, 0, 80, 1, 0, 0, 8'hFF};
        tbl[6] = '{8'h00, 1, 1, 0, 0, 88, 1, 0, 0, 8'h00};
        none   = '{0, 0, 0, 0, 8'h00};

        // Reset state
        RST = 1'b0;
        repeat (3) @(negedge CLK);
        chk("reset_p_data",     32'(P_DATA),     32'd0);
        chk("reset_data_valid", 32'(Data_Valid), 32'd0);
        chk("reset_par_err",    32'(Par_Err),    32'd0);
        chk("reset_stp_err",    32'(Stp_Err),    32'd0);
        chk("reset_busy",       32'(Busy),       32'd0);
        RST    = 1'b1;
        mon_en = 1'b1;
        repeat (5) @(negedge CLK);

        // 0xA5 without parity: Busy window and result at t0+80
        tv = '{80, 1, 0, 0, 8'hA5};
        tb0 = edge_no + 1;
        fork
            send_frame(8'hA5, 0, 0, 0, 0, 0, tv);
            begin
                wait_edge(tb0 + LAT);      chk("busy_at_t0",    32'(Busy), 32'd0);
                wait_edge(tb0 + 1 + LAT);  chk("busy_at_t0p1",  32'(Busy), 32'd1);
                wait_edge(tb0 + 79 + LAT); chk("busy_at_t0p79", 32'(Busy), 32'd1);
                wait_edge(tb0 + 80 + LAT); chk("busy_at_t0p80", 32'(Busy), 32'd0);
            end
        join
        repeat (20) @(negedge CLK);

        // Directed frame table
        for (int i = 0; i < 7; i++) begin
            tv = '{tbl[i].off, tbl[i].dv, tbl[i].pe, tbl[i].se, tbl[i].pdata};
            send_frame(tbl[i].data, tbl[i].pen, tbl[i].ptype, tbl[i].bad_par,
                       tbl[i].bad_stop, 0, tv);
            repeat (20) @(negedge CLK);
            chk("busy_idle_after_frame", 32'(Busy), 32'd0);
        end

        // Back-to-back 0x01 then 0xFE: results at t0+80 and t0+160
        tv = '{80, 1, 0, 0, 8'h01};
        send_frame(8'h01, 0, 0, 0, 0, 0, tv);
        tv = '{80, 1, 0, 0, 8'hFE};
        send_frame(8'hFE, 0, 0, 0, 0, 0, tv);
        repeat (20) @(negedge CLK);

        // Start glitch: two low cycles, no pulses, Busy drops by t0+8
        Par_En = 1'b0;
        tb0    = edge_no + 1;
        RX_In  = 1'b0;
        repeat (2) @(negedge CLK);
        RX_In = 1'b1;
        wait_edge(tb0 + 1 + LAT); chk("glitch_busy_high", 32'(Busy), 32'd1);
        wait_edge(tb0 + 8 + LAT); chk("glitch_busy_low",  32'(Busy), 32'd0);
        repeat (100) @(negedge CLK);

        // Break: line low for 162 cycles, Stp_Err every frame, then idle
        tb0 = edge_no + 1;
        exp_q.push_back('{tb0 + 80 + LAT,  0, 0, 1, last_good});
        exp_q.push_back('{tb0 + 160 + LAT, 0, 0, 1, last_good});
        RX_In = 1'b0;
        repeat (162) @(negedge CLK);
        RX_In = 1'b1;
        wait_edge(tb0 + 170 + LAT);
        chk("break_busy_released", 32'(Busy), 32'd0);
        repeat (20) @(negedge CLK);

        // Reset at t0+40 in the middle of a frame
        tb0   = edge_no + 1;
        RX_In = 1'b0;
        repeat (OS) @(negedge CLK);
        for (int b = 0; b < 4; b++) begin
            RX_In = (b == 1);
            repeat (OS) @(negedge CLK);
        end
        chk("midframe_busy", 32'(Busy), 32'd1);
        RST   = 1'b0;
        RX_In = 1'b1;
        @(negedge CLK);
        chk("midrst_edge",       32'(edge_no),    32'(tb0 + 40));
        chk("midrst_p_data",     32'(P_DATA),     32'd0);
        chk("midrst_data_valid", 32'(Data_Valid), 32'd0);
        chk("midrst_par_err",    32'(Par_Err),    32'd0);
        chk("midrst_stp_err",    32'(Stp_Err),    32'd0);
        chk("midrst_busy",       32'(Busy),       32'd0);
        RST       = 1'b1;
        last_good = 8'h00;
        repeat (20) @(negedge CLK);
        send_frame(8'h77, 0, 0, 0, 0, 1, none);
        repeat (20) @(negedge CLK);

        // Random frames, gaps from zero (back-to-back) upward
        for (int k = 0; k < 12; k++) begin
            logic [7:0] d;
            bit         pen;
            bit         pt;
            bit         bp;
            bit         bs;
            int         gap;
            d   = 8'($urandom);
            pen = 1'($urandom);
            pt  = 1'($urandom);
            bp  = pen && ($urandom_range(0, 3) == 0);
            bs  = ($urandom_range(0, 4) == 0);
            send_frame(d, pen, pt, bp, bs, 1, none);
            gap = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 15));
            repeat (gap) @(negedge CLK);
        end
        repeat (150) @(negedge CLK);
        chk("all_results_seen", 32'(exp_q.size()), 32'd0);
        chk("final_busy",       32'(Busy),         32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/uart_rx_top.md
Name: uart_rx_top

Overview:
- UART receiver: the receive-side counterpart of the team's UART transmitter, with the same frame format.
- Frame format: start bit (0), DATA_WIDTH data bits LSB first, optional parity bit, one stop bit (1). Idle line is high.
- Oversamples RX_In at OVERSAMPLE clocks per bit and majority-votes each bit.
- Deserializes the frame, checks parity and stop bits, and presents parallel data with a one-cycle valid pulse to the host logic.

Parameters:
- DATA_WIDTH, 8, number of data bits per frame.
- OVERSAMPLE, 8, clocks per bit. Legal values are 8, 16 and 32 only.

Ports:
- CLK  input  1  system clock; all logic on the rising edge.
- RST  input  1  reset, synchronous, active-low.
- RX_In  input  1  serial line; idle high.
- Par_En  input  1  1 = frame carries a parity bit.
- Par_Type  input  1  0 = even parity, 1 = odd parity.
- P_DATA  output  DATA_WIDTH  last correctly received data word.
- Data_Valid  output  1  one-cycle pulse: P_DATA has been updated.
- Par_Err  output  1  one-cycle pulse: parity mismatch.
- Stp_Err  output  1  one-cycle pulse: stop bit sampled as 0.
- Busy  output  1  high while a frame is being received.

Behaviour:
- Reset: when RST=0 at a rising edge, all outputs are forced to 0 (P_DATA=0, pulses=0, Busy=0), the FSM goes to IDLE and all counters clear. Reset overrides any frame in progress; no flags are emitted for the aborted frame.
- Counters:
  - edge_cnt runs 0..OVERSAMPLE-1 within each bit.
  - bit_cnt counts data bits 0..DATA_WIDTH-1.
- Sampling:
  - RX_In is sampled at edge_cnt = OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1.
  - The bit value is the 2-of-3 majority, valid from edge_cnt = OVERSAMPLE/2+2.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: when RX_In=0 is seen, go to START with edge_cnt=0. Busy=1 from the next cycle. Par_En and Par_Type are latched at this point; they are ignored for the rest of the frame.
  - START: at edge_cnt=OVERSAMPLE-1:
    - if the majority is 0, go to DATA;
    - if the majority is 1 (glitch), go to IDLE with no flags, Busy=0.
  - DATA: at the end of each bit, shift the majority into the shift register at position bit_cnt (LSB first). After bit DATA_WIDTH-1, go to PARITY if the latched Par_En=1, else STOP.
  - PARITY: compute expected parity = XOR of the data bits XOR Par_Type. Mismatch with the received parity bit sets an internal error flag. Go to STOP.
  - STOP: at edge_cnt=OVERSAMPLE-1, in a single registered update:
    - stop bit majority 0: Stp_Err=1;
    - parity flag set: Par_Err=1;
    - neither error: load P_DATA and set Data_Valid=1.
    - In all cases Busy=0 and the FSM returns to IDLE.
- Errored frames: P_DATA holds its previous value.
- Both errors at once: Par_Err and Stp_Err may assert in the same cycle; Data_Valid stays 0.
- Latency:
  - N = 10 + Par_En bits per frame.
  - t0 = the cycle in which IDLE first sees RX_In=0.
  - Data_Valid is high in cycle t0 + N*OVERSAMPLE; all pulses last exactly 1 cycle.
- Back-to-back frames: IDLE accepts a new start edge in the very cycle after the STOP update. A start bit that immediately follows a stop bit must be received with no lost cycles.
- RX_In held low indefinitely (break):
  - the frame completes with Stp_Err;
  - the FSM re-enters START on the next cycle, because RX_In is still 0;
  - this repeats for as long as the line stays low.

Optional Feature:
- Macro: UART_RX_SYNC_EN.
- Defined: RX_In passes through a two-flop synchronizer that resets to 1. All latencies grow by 2 cycles (Data_Valid at t0+N*OVERSAMPLE+2, with t0 measured at the port).
- Undefined: RX_In feeds the FSM directly and the latency is as stated above.

Test Plan:
- OVERSAMPLE=8, Par_En=0, send 0xA5 with start at t0 → Data_Valid=1 at t0+80 only, P_DATA=0xA5, Par_Err=0, Stp_Err=0; Busy high from t0+1 to t0+79.
- Par_En=1, Par_Type=0, send 0x3C with parity bit 0 → Data_Valid at t0+88, P_DATA=0x3C. Repeat with parity bit 1 → Par_Err=1 for one cycle, Data_Valid=0, P_DATA stays 0x3C.
- Par_En=0, send 0x5A with stop bit 0 → Stp_Err=1 at t0+80, P_DATA unchanged. Then release the line high → IDLE, Busy=0.
- RX_In low for 2 cycles then high → no Data_Valid and no error pulses; Busy back to 0 by t0+8.
- Frames 0x01 and 0xFE sent back-to-back with no idle gap → Data_Valid pulses at t0+80 and t0+160, with P_DATA=0x01 then 0xFE.
- Assert RST=0 for 1 cycle at t0+40 mid-frame → all outputs 0, no pulses for that frame; a following frame 0x77 is received correctly.
